count_sweep_ctrl: RTL and testbench

- Sequencer for a bounded up/down counter.
- On a start request, runs the counter through N "passes"; one pass is a ramp lo -> hi -> lo.
- Drives the counter's load, enable and direction controls, and reports busy/done to the requesting block.
- Sits between a control requester (software-visible register block or FSM) and the counter datapath; the counter is instantiated internally.

---
 rtl/count_sweep_pkg.sv | 25 ++
 rtl/count_sweep_ctrl_updown_counter.sv | 45 ++++
 rtl/count_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_count_sweep_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sweep_pkg.sv
//==============================================================================
// Module      : count_sweep_pkg
// Description : Shared types and defaults for the count_sweep_ctrl sequencer
//               and its up/down counter datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package count_sweep_pkg;

  // Default datapath sizing
  localparam int unsigned c_DEFAULT_WIDTH  = 3;
  localparam int unsigned c_DEFAULT_PASS_W = 4;

  // Sweep controller states, explicitly encoded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

endpackage : count_sweep_pkg

`default_nettype wire

// File: rtl/count_sweep_ctrl_updown_counter.sv
//==============================================================================
// Module      : updown_counter
// Description : Loadable modulo-2^WIDTH up/down counter.
//               Priority: reset > load > en. When en is set, up selects
//               increment (1) or decrement (0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module updown_counter
  import count_sweep_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;

  // Counter register: load has priority over stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= d;
    end else if (en) begin
      if (up) begin
        cnt_q <= cnt_q + WIDTH'(1);
      end else begin
        cnt_q <= cnt_q - WIDTH'(1);
      end
    end
  end

  assign q = cnt_q;

endmodule : updown_counter

`default_nettype wire

// File: rtl/count_sweep_ctrl.sv
//==============================================================================
// Module      : count_sweep_ctrl
// Description : Sequencer that sweeps an internal up/down counter through a
//               requested number of lo -> hi -> lo passes. Reports busy while
//               sweeping, a one-cycle done pulse on normal completion and a
//               one-cycle err pulse when a start request is rejected.
//               Optional build macro COUNT_SWEEP_PASS_CNT_EN adds the
//               pass_cnt output reporting completed passes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module count_sweep_ctrl
  import count_sweep_pkg::*;
#(
  parameter int WIDTH  = c_DEFAULT_WIDTH,
  parameter int PASS_W = c_DEFAULT_PASS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  cnt,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef COUNT_SWEEP_PASS_CNT_EN
  ,
  output logic [PASS_W-1:0] pass_cnt
`endif
);

  //--------------------------------------------------------------------------
  // State and latched request
  //--------------------------------------------------------------------------
  sweep_state_t      state_q;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  hi_q;
  logic [PASS_W-1:0] rem_q;
  logic              dir_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  //--------------------------------------------------------------------------
  // Decode
  //--------------------------------------------------------------------------
  logic w_start_ok;   // request is well formed (lo<=hi, passes!=0)
  logic w_accept;     // start taken this cycle
  logic w_at_hi;      // counter sits on the upper bound
  logic w_at_lo;      // counter sits on the lower bound
  logic w_flat;       // degenerate sweep, lo==hi, counter never moves
  logic w_last_pass;  // the current pass is the final one
  logic w_advance;    // sweeping and neither frozen nor aborted

  assign w_start_ok  = (lo <= hi) && (passes != '0);
  assign w_accept    = (state_q == IDLE) && start && w_start_ok;
  assign w_at_hi     = (cnt == hi_q);
  assign w_at_lo     = (cnt == lo_q);
  assign w_flat      = (lo_q == hi_q);
  assign w_last_pass = (rem_q == PASS_W'(1));
  assign w_advance   = ((state_q == UP) || (state_q == DOWN)) && !abort && !pause;

  //--------------------------------------------------------------------------
  // Counter control
  //--------------------------------------------------------------------------
  logic             w_load;
  logic             w_en;
  logic             w_up;
  logic [WIDTH-1:0] w_load_val;

  assign w_load_val = lo;

  // Steer the counter: load lo on accept, otherwise step toward the active bound
  always_comb begin
    w_load = 1'b0;
    w_en   = 1'b0;
    w_up   = 1'b0;
    case (state_q)
      IDLE: begin
        w_load = w_accept;
      end
      UP: begin
        if (w_advance) begin
          if (!w_at_hi) begin
            w_en = 1'b1;
            w_up = 1'b1;
          end else if (!w_flat) begin
            // turning point: first step of the descent
            w_en = 1'b1;
            w_up = 1'b0;
          end
        end
      end
      DOWN: begin
        if (w_advance) begin
          if (!w_at_lo) begin
            w_en = 1'b1;
            w_up = 1'b0;
          end else if (!w_last_pass && !w_flat) begin
            // turning point: first step of the next ascent
            w_en = 1'b1;
            w_up = 1'b1;
          end
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .d     (w_load_val),
    .en    (w_en),
    .up    (w_up),
    .q     (cnt)
  );

  //--------------------------------------------------------------------------
  // Sweep FSM with registered status outputs
  //--------------------------------------------------------------------------

  // Sequence the passes, track remaining passes and register busy/dir/done/err
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // pulses default low; set only in the cycle after their cause
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (w_start_ok) begin
              lo_q    <= lo;
              hi_q    <= hi;
              rem_q   <= passes;
              state_q <= UP;
              dir_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        UP: begin
          if (abort) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (!pause && w_at_hi) begin
            state_q <= DOWN;
            dir_q   <= 1'b0;
          end
        end
        DOWN: begin
          if (abort) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (!pause && w_at_lo) begin
            if (w_last_pass) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rem_q   <= rem_q - PASS_W'(1);
              state_q <= UP;
              dir_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          // completion already signalled; abort here has the same outcome
          state_q <= IDLE;
          dir_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          dir_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dir  = dir_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

`ifdef COUNT_SWEEP_PASS_CNT_EN
  //--------------------------------------------------------------------------
  // Completed-pass counter
  //--------------------------------------------------------------------------
  logic [PASS_W-1:0] pass_cnt_q;

  // Clear on a new sweep, bump each time the descent reaches lo
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt_q <= '0;
    end else if (w_accept) begin
      pass_cnt_q <= '0;
    end else if ((state_q == DOWN) && w_advance && w_at_lo) begin
      pass_cnt_q <= pass_cnt_q + PASS_W'(1);
    end
  end

  assign pass_cnt = pass_cnt_q;
`endif

endmodule : count_sweep_ctrl

`default_nettype wire

// File: tb/tb_count_sweep_ctrl.sv
//==============================================================================
// Module      : tb_count_sweep_ctrl
// Description : Self-checking bench for count_sweep_ctrl. Expected counter
//               trajectories are generated from the sweep rules as a list of
//               (cnt, dir) values per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_count_sweep_ctrl;

  localparam int WIDTH  = 3;
  localparam int PASS_W = 4;
  localparam int GUARD  = 600;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [PASS_W-1:0] passes;
  logic              pause;
  logic              abort;
  logic [WIDTH-1:0]  cnt;
  logic              dir;
  logic              busy;
  logic              done;
  logic              err;
`ifdef COUNT_SWEEP_PASS_CNT_EN
  logic [PASS_W-1:0] pass_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // expected per-cycle trajectory of one sweep
  int exp_cnt[$];
  bit exp_dir[$];

  always #5 clk = ~clk;

  count_sweep_ctrl #(
    .WIDTH  (WIDTH),
    .PASS_W (PASS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lo       (lo),
    .hi       (hi),
    .passes   (passes),
    .pause    (pause),
    .abort    (abort),
    .cnt      (cnt),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef COUNT_SWEEP_PASS_CNT_EN
    ,
    .pass_cnt (pass_cnt)
`endif
  );

  // Sweep trajectory: start at lo going up, then each pass climbs to hi and
  // descends back to lo. A flat sweep shows lo twice per pass (up, then down).
  function automatic void build_sweep(input int l, input int h, input int p);
    exp_cnt.delete();
    exp_dir.delete();
    if (l == h) begin
      for (int i = 0; i < p; i++) begin
        exp_cnt.push_back(l); exp_dir.push_back(1'b1);
        exp_cnt.push_back(l); exp_dir.push_back(1'b0);
      end
    end else begin
      exp_cnt.push_back(l); exp_dir.push_back(1'b1);
      for (int i = 0; i < p; i++) begin
        for (int v = l + 1; v <= h; v++) begin
          exp_cnt.push_back(v); exp_dir.push_back(1'b1);
        end
        for (int v = h - 1; v >= l; v--) begin
          exp_cnt.push_back(v); exp_dir.push_back(1'b0);
        end
      end
    end
  endfunction

  task automatic drive_start(input int l, input int h, input int p);
    @(negedge clk);
    start  = 1'b1;
    lo     = WIDTH'(l);
    hi     = WIDTH'(h);
    passes = PASS_W'(p);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    lo = '0; hi = '0; passes = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt !== '0 || dir !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: cnt=%0d dir=%0b busy=%0b, expected cnt=0 dir=0 busy=0", cnt, dir, busy);
    end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: done=%0b err=%0b, expected 0 0", done, err);
    end
    reset = 1'b0;
  endtask

  // Directed and randomized sweeps, optionally with random pause
  task automatic test_sweeps();
    int l, h, p, pct, idx, guard;
    bit hold;
    for (int n = 0; n < 10; n++) begin
      case (n)
        0:       begin l = 1; h = 3; p = 2; pct = 0; end
        1:       begin l = 4; h = 4; p = 2; pct = 0; end
        2:       begin l = 0; h = 7; p = 1; pct = 0; end
        default: begin
          l = $urandom_range(0, 7);
          h = $urandom_range(l, 7);
          p = $urandom_range(1, 3);
          pct = 30;
        end
      endcase
      build_sweep(l, h, p);
      drive_start(l, h, p);
      idx = 0;
      guard = 0;
      while (idx < exp_cnt.size() && guard < GUARD) begin
        @(negedge clk);
        guard++;
        start = 1'b0;
        lo = WIDTH'($urandom);
        hi = WIDTH'($urandom);
        passes = PASS_W'($urandom);
        checks++;
        if (cnt !== WIDTH'(exp_cnt[idx]) || dir !== exp_dir[idx] || busy !== 1'b1 ||
            done !== 1'b0 || err !== 1'b0) begin
          failures++;
          $display("FAIL sweep%0d_step%0d: cnt=%0d dir=%0b busy=%0b done=%0b err=%0b, expected cnt=%0d dir=%0b busy=1 done=0 err=0",
                   n, idx, cnt, dir, busy, done, err, exp_cnt[idx], exp_dir[idx]);
        end
        hold = (pct > 0) && ($urandom_range(0, 99) < pct);
        pause = hold;
        if (!hold) idx++;
      end
      if (guard >= GUARD) begin
        checks++;
        failures++;
        $display("FAIL sweep%0d_timeout: idx=%0d, expected %0d steps", n, idx, exp_cnt.size());
      end
      @(negedge clk);
      pause = 1'($urandom_range(0, 1));
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || cnt !== WIDTH'(l) || dir !== 1'b0) begin
        failures++;
        $display("FAIL sweep%0d_done: done=%0b busy=%0b cnt=%0d dir=%0b, expected done=1 busy=0 cnt=%0d dir=0",
                 n, done, busy, cnt, dir, l);
      end
`ifdef COUNT_SWEEP_PASS_CNT_EN
      checks++;
      if (pass_cnt !== PASS_W'(p)) begin
        failures++;
        $display("FAIL sweep%0d_pass_cnt: pass_cnt=%0d, expected %0d", n, pass_cnt, p);
      end
`endif
      @(negedge clk);
      pause = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || cnt !== WIDTH'(l)) begin
        failures++;
        $display("FAIL sweep%0d_idle: done=%0b busy=%0b cnt=%0d, expected done=0 busy=0 cnt=%0d",
                 n, done, busy, cnt, l);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    build_sweep(1, 5, 3);
    drive_start(1, 5, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (cnt !== WIDTH'(exp_cnt[i]) || busy !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_step%0d: cnt=%0d busy=%0b, expected cnt=%0d busy=1", i, cnt, busy, exp_cnt[i]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (cnt !== '0 || busy !== 1'b0 || done !== 1'b0 || dir !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after: cnt=%0d busy=%0b done=%0b dir=%0b, expected 0 0 0 0", cnt, busy, done, dir);
    end
    @(negedge clk);
    checks++;
    if (cnt !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle: cnt=%0d busy=%0b done=%0b, expected 0 0 0", cnt, busy, done);
    end
  endtask

  task automatic test_reject();
    // park the counter on 6 with a flat single pass
    drive_start(6, 6, 1);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (cnt !== WIDTH'(6) || busy !== 1'b0) begin
      failures++;
      $display("FAIL reject_prep: cnt=%0d busy=%0b, expected cnt=6 busy=0", cnt, busy);
    end
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      if (k == 0) begin lo = 3'd5; hi = 3'd2; passes = 4'd3; end
      else        begin lo = 3'd1; hi = 3'd3; passes = 4'd0; end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || cnt !== WIDTH'(6) || done !== 1'b0) begin
        failures++;
        $display("FAIL reject%0d_err: err=%0b busy=%0b cnt=%0d done=%0b, expected err=1 busy=0 cnt=6 done=0",
                 k, err, busy, cnt, done);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || cnt !== WIDTH'(6)) begin
        failures++;
        $display("FAIL reject%0d_after: err=%0b busy=%0b cnt=%0d, expected err=0 busy=0 cnt=6", k, err, busy, cnt);
      end
    end
  endtask

  task automatic test_pause_abort();
    int idx, guard, held;
    bit hold;
    // directed pause: three frozen cycles while showing cnt=2 on the way up
    build_sweep(0, 5, 1);
    drive_start(0, 5, 1);
    idx = 0; guard = 0; held = 0;
    while (idx < exp_cnt.size() && guard < GUARD) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      checks++;
      if (cnt !== WIDTH'(exp_cnt[idx]) || dir !== exp_dir[idx] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL pause_step%0d: cnt=%0d dir=%0b busy=%0b done=%0b, expected cnt=%0d dir=%0b busy=1 done=0",
                 idx, cnt, dir, busy, done, exp_cnt[idx], exp_dir[idx]);
      end
      hold = (exp_cnt[idx] == 2) && exp_dir[idx] && (held < 3);
      if (hold) held++;
      pause = hold;
      if (!hold) idx++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cnt !== WIDTH'(0) || guard !== exp_cnt.size() + 3) begin
      failures++;
      $display("FAIL pause_done: done=%0b cnt=%0d cycles=%0d, expected done=1 cnt=0 cycles=%0d",
               done, cnt, guard, exp_cnt.size() + 3);
    end

    // abort (with pause also high) at cnt=3 during the first climb
    build_sweep(1, 5, 2);
    drive_start(1, 5, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (cnt !== WIDTH'(exp_cnt[i]) || busy !== 1'b1) begin
        failures++;
        $display("FAIL abort_step%0d: cnt=%0d busy=%0b, expected cnt=%0d busy=1", i, cnt, busy, exp_cnt[i]);
      end
    end
    abort = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pause = 1'b0;
    checks++;
    if (busy !== 1'b0 || cnt !== WIDTH'(3) || done !== 1'b0 || dir !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: busy=%0b cnt=%0d done=%0b dir=%0b, expected busy=0 cnt=3 done=0 dir=0",
               busy, cnt, done, dir);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt !== WIDTH'(3) || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold: busy=%0b cnt=%0d done=%0b, expected busy=0 cnt=3 done=0", busy, cnt, done);
    end

    // abort in IDLE does not block a simultaneous start
    abort = 1'b1;
    start = 1'b1; lo = 3'd2; hi = 3'd2; passes = 4'd1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cnt !== WIDTH'(2) || dir !== 1'b1) begin
      failures++;
      $display("FAIL abort_idle_start: busy=%0b cnt=%0d dir=%0b, expected busy=1 cnt=2 dir=1", busy, cnt, dir);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt !== WIDTH'(2)) begin
      failures++;
      $display("FAIL abort_idle_done: done=%0b busy=%0b cnt=%0d, expected done=1 busy=0 cnt=2", done, busy, cnt);
    end
  endtask

  task automatic test_back_to_back();
    int idx, guard;
    build_sweep(2, 4, 1);
    drive_start(2, 4, 1);
    idx = 0; guard = 0;
    while (idx < exp_cnt.size() && guard < GUARD) begin
      @(negedge clk);
      guard++;
      checks++;
      if (cnt !== WIDTH'(exp_cnt[idx]) || dir !== exp_dir[idx] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL b2b_step%0d: cnt=%0d dir=%0b busy=%0b done=%0b, expected cnt=%0d dir=%0b busy=1 done=0",
                 idx, cnt, dir, busy, done, exp_cnt[idx], exp_dir[idx]);
      end
      // a second, different request arrives mid-sweep
      start = (idx == 1);
      lo = 3'd0; hi = 3'd7; passes = 4'd5;
      idx++;
    end
    @(negedge clk);
    // a request during DONE must be ignored as well
    start = 1'b1; lo = 3'd1; hi = 3'd1; passes = 4'd1;
    checks++;
    if (done !== 1'b1 || cnt !== WIDTH'(2) || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: done=%0b cnt=%0d busy=%0b, expected done=1 cnt=2 busy=0", done, cnt, busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || cnt !== WIDTH'(2) || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_start: busy=%0b cnt=%0d done=%0b, expected busy=0 cnt=2 done=0", busy, cnt, done);
    end
  endtask

  initial begin
    test_reset();
    test_sweeps();
    test_reset_mid_sweep();
    test_reject();
    test_pause_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule : tb_count_sweep_ctrl

`default_nettype wire
